// File: rtl/branch_cmp_pkg.sv
// branch_cmp_pkg: compare-mode encodings and pipeline depth limits for branch_cmp_pipe
package branch_cmp_pkg;
  typedef logic [2:0] cmp_mode_t;
  localparam cmp_mode_t MODE_EQ  = 3'd0;
  localparam cmp_mode_t MODE_NE  = 3'd1;
  localparam cmp_mode_t MODE_LEZ = 3'd2;
  localparam cmp_mode_t MODE_GTZ = 3'd3;
  localparam cmp_mode_t MODE_LTZ = 3'd4;
  localparam cmp_mode_t MODE_GEZ = 3'd5;
  localparam cmp_mode_t MODE_LT  = 3'd6;
  localparam cmp_mode_t MODE_LTU = 3'd7;
  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 2;
endpackage

// File: rtl/branch_cmp_core.sv
// branch_cmp_core: combinational branch-condition evaluation for all eight compare modes
module branch_cmp_core
  import branch_cmp_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  cmp_mode_t        mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             taken
);
  logic neg, nz;
  assign neg = a[WIDTH-1];
  assign nz  = |a;
  always_comb begin
    taken = 1'b0;
    case (mode)
      MODE_EQ:  taken = a == b;
      MODE_NE:  taken = a != b;
      MODE_LEZ: taken = neg | ~nz;
      MODE_GTZ: taken = ~neg & nz;
      MODE_LTZ: taken = neg;
      MODE_GEZ: taken = ~neg;
      MODE_LT:  taken = $signed(a) < $signed(b);
      MODE_LTU: taken = a < b;
      default:  taken = 1'b0;
    endcase
  end
endmodule

// File: rtl/branch_cmp_pipe.sv
// branch_cmp_pipe: pipelined branch-condition unit with valid/stall/flush and a sideband tag.
// Define BRANCH_CMP_STAT_EN to add the retired/taken statistics counters.
module branch_cmp_pipe
  import branch_cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LAT   = 1,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  cmp_mode_t        mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [TAG_W-1:0] tag,
  input  logic             stall,
  input  logic             flush,
  output logic             out_valid,
  output logic             taken,
  output logic [TAG_W-1:0] out_tag
`ifdef BRANCH_CMP_STAT_EN
  ,
  output logic [31:0]      stat_total,
  output logic [31:0]      stat_taken
`endif
);
  localparam int L = (LAT < LAT_MIN) ? LAT_MIN : (LAT > LAT_MAX) ? LAT_MAX : LAT;
  cmp_mode_t        ev_mode;
  logic [WIDTH-1:0] ev_a, ev_b;
  logic [TAG_W-1:0] ev_tag;
  logic             ev_valid, ev_taken;
  branch_cmp_core #(.WIDTH(WIDTH)) u_core (
    .mode  (ev_mode),
    .a     (ev_a),
    .b     (ev_b),
    .taken (ev_taken)
  );
  if (L == 1) begin : g_direct
    assign ev_mode  = mode;
    assign ev_a     = a;
    assign ev_b     = b;
    assign ev_tag   = tag;
    assign ev_valid = in_valid;
  end else begin : g_stage1
    cmp_mode_t        s1_mode;
    logic [WIDTH-1:0] s1_a, s1_b;
    logic [TAG_W-1:0] s1_tag;
    logic             s1_valid;
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        s1_valid <= 1'b0;
        s1_mode  <= MODE_EQ;
        s1_a     <= '0;
        s1_b     <= '0;
        s1_tag   <= '0;
      end else if (flush) begin
        s1_valid <= 1'b0;
      end else if (!stall) begin
        s1_valid <= in_valid;
        s1_mode  <= mode;
        s1_a     <= a;
        s1_b     <= b;
        s1_tag   <= tag;
      end
    assign ev_mode  = s1_mode;
    assign ev_a     = s1_a;
    assign ev_b     = s1_b;
    assign ev_tag   = s1_tag;
    assign ev_valid = s1_valid;
  end
  // flush only kills valid bits; taken/out_tag may keep stale data
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      out_valid <= 1'b0;
      taken     <= 1'b0;
      out_tag   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (!stall) begin
      out_valid <= ev_valid;
      taken     <= ev_taken;
      out_tag   <= ev_tag;
    end
`ifdef BRANCH_CMP_STAT_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      stat_total <= '0;
      stat_taken <= '0;
    end else if (out_valid && !stall && !flush) begin
      stat_total <= stat_total + 32'd1;
      stat_taken <= stat_taken + {31'd0, taken};
    end
`endif
endmodule

// File: tb/tb_branch_cmp_pipe.sv
// tb_branch_cmp_pipe: directed self-checking bench for branch_cmp_pipe at LAT=1 and LAT=2
module tb_branch_cmp_pipe;
  import branch_cmp_pkg::*;
  logic        clk = 1'b0;
  logic        rst, in_valid, stall, flush;
  cmp_mode_t   mode;
  logic [31:0] a, b, tag;
  logic        ov1, tk1, ov2, tk2;
  logic [31:0] ot1, ot2;
`ifdef BRANCH_CMP_STAT_EN
  logic [31:0] tot1, tkn1, tot2, tkn2;
`endif
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_cmp_pipe #(.WIDTH(32), .LAT(1), .TAG_W(32)) u1 (
    .clk(clk), .reset(rst), .in_valid(in_valid), .mode(mode), .a(a), .b(b), .tag(tag),
    .stall(stall), .flush(flush), .out_valid(ov1), .taken(tk1), .out_tag(ot1)
`ifdef BRANCH_CMP_STAT_EN
    , .stat_total(tot1), .stat_taken(tkn1)
`endif
  );
  branch_cmp_pipe #(.WIDTH(32), .LAT(2), .TAG_W(32)) u2 (
    .clk(clk), .reset(rst), .in_valid(in_valid), .mode(mode), .a(a), .b(b), .tag(tag),
    .stall(stall), .flush(flush), .out_valid(ov2), .taken(tk2), .out_tag(ot2)
`ifdef BRANCH_CMP_STAT_EN
    , .stat_total(tot2), .stat_taken(tkn2)
`endif
  );

  task automatic chk(input string t, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", t, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input cmp_mode_t m, input logic [31:0] va, input logic [31:0] vb, input logic [31:0] t);
    in_valid = 1'b1;
    mode     = m;
    a        = va;
    b        = vb;
    tag      = t;
  endtask

  cmp_mode_t   vm [10] = '{MODE_EQ, MODE_NE, MODE_LT, MODE_LTU, MODE_LTZ,
                           MODE_GEZ, MODE_LEZ, MODE_GTZ, MODE_LT, MODE_LTU};
  logic [31:0] va [10] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h80000000, 32'h80000000,
                           32'h80000000, 32'h0, 32'h0, 32'h5, 32'h5};
  logic [31:0] vb [10] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 32'h1, 32'h1,
                           32'h1, 32'h1, 32'h1, 32'h5, 32'h5};
  logic        vt [10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    rst = 1'b1; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    mode = MODE_EQ; a = '0; b = '0; tag = '0;
    #2;
    chk("rst ov1", {31'd0, ov1}, 32'd0);
    chk("rst tk1", {31'd0, tk1}, 32'd0);
    chk("rst ot1", ot1, 32'd0);
    chk("rst ov2", {31'd0, ov2}, 32'd0);
    chk("rst tk2", {31'd0, tk2}, 32'd0);
    chk("rst ot2", ot2, 32'd0);
    tick();
    rst = 1'b0;
    // LAT=1 mode sweep including boundary operands
    for (int i = 0; i < 10; i++) begin
      req(vm[i], va[i], vb[i], 32'd100 + 32'(i));
      tick();
      chk($sformatf("sweep%0d ov", i), {31'd0, ov1}, 32'd1);
      chk($sformatf("sweep%0d tk", i), {31'd0, tk1}, {31'd0, vt[i]});
      chk($sformatf("sweep%0d tag", i), ot1, 32'd100 + 32'(i));
    end
    in_valid = 1'b0;
    tick(); tick(); tick();
    // LAT=2 back-to-back
    req(MODE_EQ, 32'd3, 32'd3, 32'd1);
    tick();
    chk("b2b e1 ov2", {31'd0, ov2}, 32'd0);
    req(MODE_NE, 32'd3, 32'd3, 32'd2);
    tick();
    chk("b2b e2 ov2", {31'd0, ov2}, 32'd1);
    chk("b2b e2 tag", ot2, 32'd1);
    chk("b2b e2 tk", {31'd0, tk2}, 32'd1);
    req(MODE_LTU, 32'd1, 32'd2, 32'd3);
    tick();
    chk("b2b e3 ov2", {31'd0, ov2}, 32'd1);
    chk("b2b e3 tag", ot2, 32'd2);
    chk("b2b e3 tk", {31'd0, tk2}, 32'd0);
    in_valid = 1'b0;
    tick();
    chk("b2b e4 ov2", {31'd0, ov2}, 32'd1);
    chk("b2b e4 tag", ot2, 32'd3);
    chk("b2b e4 tk", {31'd0, tk2}, 32'd1);
    tick();
    chk("b2b e5 ov2", {31'd0, ov2}, 32'd0);
    // stall with two requests in flight
    req(MODE_EQ, 32'd7, 32'd7, 32'd10);
    tick();
    req(MODE_NE, 32'd7, 32'd7, 32'd11);
    tick();
    stall = 1'b1;
    req(MODE_EQ, 32'd9, 32'd9, 32'd99);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall%0d ov2", i), {31'd0, ov2}, 32'd1);
      chk($sformatf("stall%0d tag", i), ot2, 32'd10);
      chk($sformatf("stall%0d tk", i), {31'd0, tk2}, 32'd1);
    end
    stall = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("unstall ov2", {31'd0, ov2}, 32'd1);
    chk("unstall tag", ot2, 32'd11);
    chk("unstall tk", {31'd0, tk2}, 32'd0);
    tick();
    chk("unstall drain ov2", {31'd0, ov2}, 32'd0);
    // flush together with stall
    req(MODE_EQ, 32'd1, 32'd1, 32'd20);
    tick();
    req(MODE_EQ, 32'd1, 32'd1, 32'd21);
    tick();
    chk("preflush ov2", {31'd0, ov2}, 32'd1);
    chk("preflush tag", ot2, 32'd20);
    flush = 1'b1;
    stall = 1'b1;
    req(MODE_EQ, 32'd1, 32'd1, 32'd77);
    tick();
    chk("flush ov1", {31'd0, ov1}, 32'd0);
    chk("flush ov2", {31'd0, ov2}, 32'd0);
    flush = 1'b0;
    stall = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("postflush1 ov2", {31'd0, ov2}, 32'd0);
    tick();
    chk("postflush2 ov2", {31'd0, ov2}, 32'd0);
    req(MODE_GEZ, 32'd0, 32'd0, 32'd30);
    tick();
    chk("refill ov1", {31'd0, ov1}, 32'd1);
    chk("refill tag1", ot1, 32'd30);
    chk("refill tk1", {31'd0, tk1}, 32'd1);
    chk("refill e1 ov2", {31'd0, ov2}, 32'd0);
    in_valid = 1'b0;
    tick();
    chk("refill ov2", {31'd0, ov2}, 32'd1);
    chk("refill tag2", ot2, 32'd30);
    chk("refill tk2", {31'd0, tk2}, 32'd1);
    // asynchronous reset with valid requests in flight
    req(MODE_EQ, 32'd4, 32'd4, 32'h55);
    tick();
    tick();
    chk("inflight ov1", {31'd0, ov1}, 32'd1);
    chk("inflight ov2", {31'd0, ov2}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst ov1", {31'd0, ov1}, 32'd0);
    chk("arst tk1", {31'd0, tk1}, 32'd0);
    chk("arst ot1", ot1, 32'd0);
    chk("arst ov2", {31'd0, ov2}, 32'd0);
    chk("arst tk2", {31'd0, tk2}, 32'd0);
    chk("arst ot2", ot2, 32'd0);
    rst = 1'b0;
    in_valid = 1'b0;
`ifdef BRANCH_CMP_STAT_EN
    tick();
    for (int i = 0; i < 10; i++) begin
      req(i < 4 ? MODE_EQ : MODE_NE, 32'(i), 32'(i), 32'(i));
      tick();
    end
    in_valid = 1'b0;
    tick(); tick();
    flush = 1'b1;
    req(MODE_EQ, 32'd8, 32'd8, 32'd88);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    tick(); tick();
    chk("stat tot1", tot1, 32'd10);
    chk("stat tkn1", tkn1, 32'd4);
    chk("stat tot2", tot2, 32'd10);
    chk("stat tkn2", tkn2, 32'd4);
    u1.stat_total = 32'hFFFFFFFF;
    req(MODE_EQ, 32'd2, 32'd2, 32'd5);
    tick();
    in_valid = 1'b0;
    tick();
    chk("stat wrap", tot1, 32'd0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
